// File: rtl/interp_pkg.sv
// Shared constants and types for the interpolation output sequencer.
package interp_pkg;

    localparam int unsigned IN_W       = 40;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned FRAC_SHIFT = 6;

    typedef enum logic [1:0] {
        PH_SAMPLE = 2'd0,
        PH_A      = 2'd1,
        PH_B      = 2'd2,
        PH_C      = 2'd3
    } phase_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/round_sat.sv
// Round-half-up, arithmetic right shift and unsigned saturation of a signed kernel sum.
module round_sat #(
    parameter int unsigned IN_W       = 40,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FRAC_SHIFT = 6
) (
    input  logic [IN_W-1:0]  x_i,
    output logic [OUT_W-1:0] y_o
);

    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(1 << (FRAC_SHIFT - 1));
    localparam logic signed [IN_W:0] MAX_R = (IN_W+1)'((1 << OUT_W) - 1);

    logic signed [IN_W:0] x_ext;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] r;

    // One guard bit keeps the rounding add from overflowing.
    always_comb begin
        x_ext = {x_i[IN_W-1], x_i};
        sum   = x_ext + RND;
        r     = sum >>> FRAC_SHIFT;
        if (r < 0) begin
            y_o = '0;
        end else if (r > MAX_R) begin
            y_o = '1;
        end else begin
            y_o = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/interp_output_sequencer.sv
// Captures one window result (sample + converted A/B/C) and serializes it as four
// output beats with valid/ready flow control.
module interp_output_sequencer
    import interp_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OUT_W-1:0]  in_sample,
    input  logic [IN_W-1:0]   in_a,
    input  logic [IN_W-1:0]   in_b,
    input  logic [IN_W-1:0]   in_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [1:0]        out_phase,
    output logic              out_last
);

    seq_state_t       state_q, state_d;
    phase_t           phase_q, phase_d;
    phase_t           phase_nxt;
    logic [OUT_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [OUT_W-1:0] conv_a, conv_b, conv_c;
    logic             accept;

    round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_a (.x_i(in_a), .y_o(conv_a));
    round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_b (.x_i(in_b), .y_o(conv_b));
    round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_c (.x_i(in_c), .y_o(conv_c));

    // Combinational from out_ready so a new window can follow the last beat with no bubble.
    assign in_ready = !reset && ((state_q == IDLE) || (phase_q == PH_C && out_ready));
    assign accept   = in_valid && in_ready;

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_phase = phase_q;
    assign out_last  = last_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        data_d    = data_q;
        phase_nxt = phase_t'(2'(phase_q) + 2'd1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    phase_d = PH_SAMPLE;
                    data_d  = in_sample;
                    a_d     = conv_a;
                    b_d     = conv_b;
                    c_d     = conv_c;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (phase_q == PH_C) begin
                        if (accept) begin
                            phase_d = PH_SAMPLE;
                            data_d  = in_sample;
                            a_d     = conv_a;
                            b_d     = conv_b;
                            c_d     = conv_c;
                        end else begin
                            state_d = IDLE;
                            phase_d = PH_SAMPLE;
                        end
                    end else begin
                        phase_d = phase_nxt;
                        case (phase_nxt)
                            PH_A:    data_d = a_q;
                            PH_B:    data_d = b_q;
                            PH_C:    data_d = c_q;
                            default: data_d = data_q;
                        endcase
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = PH_SAMPLE;
            end
        endcase

        valid_d = (state_d == EMIT);
        last_d  = (state_d == EMIT) && (phase_d == PH_C);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= PH_SAMPLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_interp_output_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops them on each output handshake.
module tb_interp_output_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sample;
    logic [39:0] in_a, in_b, in_c;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_phase;
    logic        out_last;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ph;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;

    interp_output_sequencer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_phase(out_phase), .out_last(out_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1; in_valid stays high so callers can chain windows.
    task automatic send(input logic [7:0] s, input logic [39:0] a, input logic [39:0] b,
                        input logic [39:0] c, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] ec);
        bit ok = 0;
        in_sample = s; in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never rose (t=%0t)", $time);
        end
        sb.push_back('{d: s,  ph: 2'd0, last: 1'b0});
        sb.push_back('{d: ea, ph: 2'd1, last: 1'b0});
        sb.push_back('{d: eb, ph: 2'd2, last: 1'b0});
        sb.push_back('{d: ec, ph: 2'd3, last: 1'b1});
        @(posedge clock); #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_sample = 8'($urandom);
        in_a = {8'($urandom), 32'($urandom)};
        in_b = {8'($urandom), 32'($urandom)};
        in_c = {8'($urandom), 32'($urandom)};
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats still expected (t=%0t)", sb.size(), $time);
        end
        @(posedge clock); #1;
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: data %0d phase %0d with empty scoreboard", out_data, out_phase);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data",  64'(out_data),  64'(e.d));
                    chk("beat_phase", 64'(out_phase), 64'(e.ph));
                    chk("beat_last",  64'(out_last),  64'(e.last));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; out_ready = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        chk("post_reset_out_data", 64'(out_data), 64'd0);
        chk("post_reset_out_phase", 64'(out_phase), 64'd0);
        chk("post_reset_out_last", 64'(out_last), 64'd0);
        @(posedge clock); #1;

        // Single window
        send(8'd100, 40'd3200, 40'd6400, -40'sd640, 8'd50, 8'd100, 8'd0);
        idle_inputs();
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        chk("latency_out_phase", 64'(out_phase), 64'd0);
        wait_drain();
        chk("single_in_ready_after", 64'(in_ready), 64'd1);

        // Rounding and saturation boundaries
        send(8'd7, 40'd95, 40'd96, -40'sd32, 8'd1, 8'd2, 8'd0);
        idle_inputs();
        wait_drain();
        send(8'd8, -40'sd33, 40'd19200, 40'd16351, 8'd0, 8'd255, 8'd255);
        idle_inputs();
        wait_drain();
        send(8'd9, 40'd16287, 40'd16352, 40'h80_0000_0000, 8'd254, 8'd255, 8'd0);
        idle_inputs();
        wait_drain();
        send(8'd255, 40'h7F_FFFF_FFFF, 40'd31, 40'd32, 8'd255, 8'd0, 8'd1);
        idle_inputs();
        wait_drain();

        // Back-to-back windows
        send(8'd11, 40'd640, 40'd1280, 40'd1920, 8'd10, 8'd20, 8'd30);
        fork
            begin
                send(8'd12, 40'd2560, 40'd3200, 40'd3840, 8'd40, 8'd50, 8'd60);
                send(8'd13, 40'd4480, 40'd5120, 40'd5760, 8'd70, 8'd80, 8'd90);
                idle_inputs();
            end
            begin
                int v = 0, bad = 0, pulses = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clock);
                    if (out_valid) v++;
                    if (in_ready) pulses++;
                    if (in_ready && out_phase != 2'd3) bad++;
                end
                chk("b2b_valid_cycles", 64'(v), 64'd12);
                chk("b2b_in_ready_off_phase3", 64'(bad), 64'd0);
                chk("b2b_in_ready_pulses", 64'(pulses), 64'd3);
            end
        join
        wait_drain();

        // Backpressure during phase 1
        send(8'd21, 40'd1600, 40'd1664, 40'd1728, 8'd25, 8'd26, 8'd27);
        idle_inputs();
        @(posedge clock); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_data_hold", 64'(out_data), 64'd25);
            chk("bp_phase_hold", 64'(out_phase), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset during phase 2
        send(8'd31, 40'd2240, 40'd2304, 40'd2368, 8'd35, 8'd36, 8'd37);
        idle_inputs();
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("pre_reset_phase", 64'(out_phase), 64'd2);
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_out_phase", 64'(out_phase), 64'd0);
        chk("mid_reset_in_ready", 64'(in_ready), 64'd0);
        chk("mid_reset_out_last", 64'(out_last), 64'd0);
        reset = 1'b0;
        #1;
        chk("after_reset_out_data", 64'(out_data), 64'd0);
        chk("after_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        send(8'd41, 40'd2880, 40'd2944, 40'd3008, 8'd45, 8'd46, 8'd47);
        idle_inputs();
        wait_drain();

        // Idle gap
        send(8'd51, 40'd3520, 40'd3584, 40'd3648, 8'd55, 8'd56, 8'd57);
        idle_inputs();
        wait_drain();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("gap_out_valid", 64'(out_valid), 64'd0);
            chk("gap_in_ready", 64'(in_ready), 64'd1);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
